instr_register_ctrl: RTL and testbench
======================================

# instr_register_ctrl

Controller that shares the instruction register's single write port between NUM_REQ requesters and sequences in-order read-back to one consumer. The 32-entry register is managed as a circular queue with allocated write and read pointers and an occupancy count. The block sits between the instruction sources and instr_register: it drives load_en, write_pointer, read_pointer, opcode, operand_a and operand_b, and consumes instruction_word.

## Interface
Parameters:
- NUM_REQ, 2, number of write requesters (2..4)
- DEPTH, 32, register entries; must equal 2**$bits(address_t)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_valid  in  NUM_REQ  requester i offers an instruction
- req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready
- req_opcode  in  NUM_REQ x opcode_t  per-requester opcode
- req_operand_a  in  NUM_REQ x operand_t  per-requester operand A (signed)
- req_operand_b  in  NUM_REQ x operand_t  per-requester operand B (signed)
- rd_req  in  1  consumer pops the oldest instruction
- rd_valid  out  1  a committed instruction is available
- rd_instr  out  instruction_t  oldest committed instruction (= instruction_word)
- load_en, write_pointer (address_t), read_pointer (address_t), opcode, operand_a, operand_b  out  to instr_register
- instruction_word  in  instruction_t  from instr_register, combinational on read_pointer
- count  out  6  allocated entries, 0..32
- full, empty  out  1  status flags

## Operation
- Arbitration: round-robin over requesters with req_valid=1; last_grant register; search starts at last_grant+1. After reset requester 0 has highest priority.
- req_ready is combinational: at most one bit set, only when full=0. It may depend on req_valid; req_valid must not depend on req_ready.
- Issue: transfer in cycle N registers the granted opcode/operands, write_pointer=wr_ptr and load_en=1 for cycle N+1. The register captures at the end of N+1. wr_ptr increments at the transfer edge and wraps 31->0.
- Back-to-back grants are allowed; load_en stays high for consecutive transfers.
- count increments on transfer and decrements on pop; a simultaneous transfer and pop leaves it unchanged. full = (count==DEPTH).
- Committed occupancy = count - load_en. empty = (committed==0) and rd_valid = !empty, so an in-flight write is never readable.
- Read: read_pointer = rd_ptr register. rd_instr passes instruction_word through. A pop (rd_valid & rd_req) advances rd_ptr with wrap 31->0. rd_req while empty is ignored.
- Full: all req_ready=0 and no state changes on the write side. A pop while full lets req_ready assert in the next cycle, not the same one.
- No opcode interpretation; data passes unmodified. Operands are passed at operand_t width with no extension or truncation.

## Timing
- Reset values: load_en=0, write_pointer=0, read_pointer=0, opcode=ZERO, operand_a=0, operand_b=0, req_ready=0 during reset cycle, rd_valid=0, count=0, empty=1, full=0, last_grant=NUM_REQ-1.
- Reset mid-operation: after the reset edge any in-flight write is dropped (load_en=0). Register contents become don't-care.
- Write latency: request accepted at edge N; data visible on rd_instr no earlier than cycle N+2.
- Read latency: 0 cycles. rd_instr is valid in the same cycle as rd_valid.

## Structure
- instr_register_pkg holds opcode_t, operand_t, address_t and instruction_t. Add DEPTH constant and count_t (6-bit) to it.
- Sub-module instr_rr_arbiter(NUM_REQ): req, last_grant -> one-hot grant and grant index. It is purely combinational; the last_grant register stays in instr_register_ctrl.

## Test plan
- Reset: hold reset 2 cycles with req_valid=2'b11 -> all outputs at reset values, req_ready=0; the first grant after reset goes to req 0.
- Fairness: both requesters valid for 4 cycles -> grants 0,1,0,1; write_pointer 0,1,2,3 on load_en cycles; count=4.
- Ordering: req0 writes ADD/5/3 then req1 writes SUB/-7/2 -> rd_valid rises 2 cycles after the first accept; pops return ADD 5 3 then SUB -7 2.
- Full/wrap: 32 writes with no pops -> full=1, req_ready=0. Pop one -> the next write goes to write_pointer=0, read_pointer=1.
- Simultaneous push/pop at count=10 -> count stays 10, both pointers advance by 1.
- Reset mid-stream: assert reset in the cycle load_en=1 -> next cycle load_en=0, count=0, empty=1.

Source files
------------

// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction types and queue geometry
package instr_register_pkg;
   typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
   typedef logic signed [31:0] operand_t;
   typedef logic [4:0] address_t;
   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;
   localparam int DEPTH = 32;
   typedef logic [5:0] count_t;
endpackage

// File: rtl/instr_rr_arbiter.sv
// instr_rr_arbiter: combinational round-robin pick starting after the last grant
module instr_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_grant_idx
);
   // scan from farthest to nearest so the requester closest after last_grant wins
   always_comb begin
      o_grant = '0;
      o_grant_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         int idx;
         idx = (int'(i_last_grant) + k) % NUM_REQ;
         if (i_req[idx]) begin
            o_grant = NUM_REQ'(1) << idx;
            o_grant_idx = IW'(idx);
         end
      end
   end
endmodule

// File: rtl/instr_register_ctrl.sv
// instr_register_ctrl: arbitrated writes and in-order reads of a circular instruction register
module instr_register_ctrl
   import instr_register_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DEPTH = instr_register_pkg::DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  opcode_t  [NUM_REQ-1:0]    req_opcode,
   input  operand_t [NUM_REQ-1:0]    req_operand_a,
   input  operand_t [NUM_REQ-1:0]    req_operand_b,
   input  logic                      rd_req,
   output logic                      rd_valid,
   output instruction_t              rd_instr,
   output logic                      load_en,
   output address_t                  write_pointer,
   output address_t                  read_pointer,
   output opcode_t                   opcode,
   output operand_t                  operand_a,
   output operand_t                  operand_b,
   input  instruction_t              instruction_word,
   output count_t                    count,
   output logic                      full,
   output logic                      empty
);
   localparam int IW = $clog2(NUM_REQ);
   logic [IW-1:0]      r_last_grant;
   logic [IW-1:0]      w_grant_idx;
   logic [NUM_REQ-1:0] w_grant;
   address_t           r_wr_ptr;
   logic               w_push;
   logic               w_pop;
   count_t             w_committed;
   instr_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx)
   );
   assign req_ready   = (full || reset) ? '0 : w_grant;
   assign w_push      = |(req_valid & req_ready);
   assign w_committed = count - count_t'(load_en);
   assign empty       = w_committed == '0;
   assign rd_valid    = !empty;
   assign full        = count == count_t'(DEPTH);
   assign w_pop       = rd_valid & rd_req;
   assign rd_instr    = instruction_word;
   // write side: latch the granted instruction and its slot for one load cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         load_en       <= 1'b0;
         write_pointer <= '0;
         opcode        <= ZERO;
         operand_a     <= '0;
         operand_b     <= '0;
         r_wr_ptr      <= '0;
         r_last_grant  <= IW'(NUM_REQ - 1);
      end else begin
         load_en <= w_push;
         if (w_push) begin
            write_pointer <= r_wr_ptr;
            r_wr_ptr      <= r_wr_ptr + address_t'(1);
            opcode        <= req_opcode[w_grant_idx];
            operand_a     <= req_operand_a[w_grant_idx];
            operand_b     <= req_operand_b[w_grant_idx];
            r_last_grant  <= w_grant_idx;
         end
      end
   end
   // read side and occupancy: pops advance the read pointer, count tracks push minus pop
   always_ff @(posedge clk) begin
      if (reset) begin
         read_pointer <= '0;
         count        <= '0;
      end else begin
         count <= count + count_t'(w_push) - count_t'(w_pop);
         if (w_pop) read_pointer <= read_pointer + address_t'(1);
      end
   end
endmodule

// File: tb/tb_instr_register_ctrl.sv
// tb_instr_register_ctrl: randomized scoreboard bench against a queue reference model
module tb_instr_register_ctrl;
   import instr_register_pkg::*;
   localparam int NR = 2;
   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NR-1:0]       req_valid = '1;
   logic [NR-1:0]       req_ready;
   opcode_t  [NR-1:0]   req_opcode;
   operand_t [NR-1:0]   req_operand_a;
   operand_t [NR-1:0]   req_operand_b;
   logic                rd_req = 1'b0;
   logic                rd_valid;
   instruction_t        rd_instr;
   logic                load_en;
   address_t            write_pointer;
   address_t            read_pointer;
   opcode_t             opcode;
   operand_t            operand_a;
   operand_t            operand_b;
   instruction_t        instruction_word;
   count_t              count;
   logic                full;
   logic                empty;
   instr_register_ctrl #(.NUM_REQ(NR)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_opcode       (req_opcode),
      .req_operand_a    (req_operand_a),
      .req_operand_b    (req_operand_b),
      .rd_req           (rd_req),
      .rd_valid         (rd_valid),
      .rd_instr         (rd_instr),
      .load_en          (load_en),
      .write_pointer    (write_pointer),
      .read_pointer     (read_pointer),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .instruction_word (instruction_word),
      .count            (count),
      .full             (full),
      .empty            (empty)
   );
   always #5 clk = ~clk;
   // instruction register stand-in: captures on load_en, reads combinationally
   instruction_t mem [32];
   always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
   assign instruction_word = mem[read_pointer];
   typedef struct {
      instruction_t ins;
      int           avail;
   } ent_t;
   ent_t         sbq[$];
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   int           last = NR - 1;
   int           wp = 0;
   int           rp = 0;
   int           exp_wp = 0;
   logic [NR-1:0] exp_ready = '0;
   bit           exp_load = 0;
   bit           fresh = 0;
   bit           started = 0;
   bit           acc = 0;
   instruction_t acc_ins;
   instruction_t load_ins;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // one cycle of stimulus: account for last cycle's accept, then drive and predict the grant
   task automatic step(int pv, int pr, bit rst);
      @(posedge clk);
      #1;
      if (reset) begin
         sbq.delete();
         last = NR - 1;
         wp = 0;
         rp = 0;
         fresh = 1;
         exp_load = 0;
         started = 1;
      end else begin
         exp_load = acc;
         if (acc) begin
            sbq.push_back(ent_t'{acc_ins, cyc + 1});
            exp_wp = wp;
            wp = (wp + 1) % 32;
            load_ins = acc_ins;
            fresh = 0;
         end
      end
      reset = rst;
      for (int i = 0; i < NR; i++) begin
         req_valid[i]     = $urandom_range(99) < pv;
         req_opcode[i]    = opcode_t'($urandom_range(7));
         req_operand_a[i] = operand_t'($urandom);
         req_operand_b[i] = operand_t'($urandom);
      end
      rd_req = !rst && ($urandom_range(99) < pr);
      exp_ready = '0;
      acc = 0;
      if (!rst && sbq.size() < 32) begin
         for (int k = 1; k <= NR; k++) begin
            int g;
            g = (last + k) % NR;
            if (!acc && req_valid[g]) begin
               exp_ready[g] = 1'b1;
               acc = 1;
               last = g;
               acc_ins = {req_opcode[g], req_operand_a[g], req_operand_b[g]};
            end
         end
      end
   endtask
   // monitor: compare DUT outputs with the model and retire popped entries
   always @(negedge clk) begin
      bit v;
      if (started) begin
         v = sbq.size() > 0 && sbq[0].avail <= cyc;
         chk("req_ready", req_ready, exp_ready);
         chk("count", count, sbq.size());
         chk("rd_valid", rd_valid, v);
         chk("empty", empty, !v);
         chk("full", full, sbq.size() == 32);
         chk("load_en", load_en, exp_load);
         chk("read_pointer", read_pointer, rp);
         if (exp_load) begin
            chk("write_pointer", write_pointer, exp_wp);
            chk("load_data", {opcode, operand_a, operand_b}, load_ins);
         end
         if (fresh) begin
            chk("rst_write_pointer", write_pointer, 0);
            chk("rst_load_data", {opcode, operand_a, operand_b}, 0);
         end
         if (v && rd_req) begin
            chk("rd_instr", rd_instr, sbq[0].ins);
            sbq.pop_front();
            rp = (rp + 1) % 32;
         end
      end
   end
   initial begin
      repeat (2) step(100, 0, 1);
      repeat (4) step(100, 0, 0);
      repeat (150) step(50, 50, 0);
      repeat (60) step(100, 0, 0);
      repeat (3) step(100, 100, 0);
      repeat (40) step(100, 100, 0);
      repeat (20) step(0, 100, 0);
      repeat (300) step(60, 40, $urandom_range(99) < 2);
      repeat (5) step(100, 0, 0);
      step(100, 0, 1);
      repeat (3) step(0, 0, 0);
      repeat (100) step(70, 60, 0);
      repeat (50) step(0, 100, 0);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
